// File: rtl/dm_pkg.sv
// Shared definitions for the dm_param memory block: controller states and the
// power-up image that the initialisation sweep writes into the array.
package dm_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam int IMAGE_LEN = 7;
    localparam int IMAGE_W   = 16;

    localparam logic [IMAGE_W-1:0] INIT_IMAGE [IMAGE_LEN] = '{
        16'h3ADC, 16'h0000, 16'h1342, 16'hADDE,
        16'hEFBE, 16'hFFFF, 16'hAAAA
    };

    // Words past the end of the image are cleared to zero.
    function automatic logic [IMAGE_W-1:0] init_word(input logic [31:0] k);
        logic [IMAGE_W-1:0] w_word;
        w_word = '0;
        if (k < 32'(IMAGE_LEN)) begin
            w_word = INIT_IMAGE[k[2:0]];
        end
        return w_word;
    endfunction

endpackage

// File: rtl/dm_init_seq.sv
// Initialisation controller: sweeps every word once after reset, then hands the
// array to the request port for the rest of operation.
module dm_init_seq
    import dm_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    output logic              o_busy,
    output logic              o_init_we,
    output logic [ADDR_W-1:0] o_init_addr,
    output logic [DATA_W-1:0] o_init_data
);

    state_e            r_state;
    state_e            w_next_state;
    logic [ADDR_W-1:0] r_cnt;
    logic [ADDR_W-1:0] w_next_cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_INIT;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
        end
    end

    // NOTE: combinational block assigns every output a default first, with
    // blocking assignments, so no path leaves a signal unassigned (no latch).
    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        o_init_we    = 1'b0;
        unique case (r_state)
            ST_INIT: begin
                o_init_we  = 1'b1;
                w_next_cnt = r_cnt + 1'b1;
                if (r_cnt == '1) begin
                    w_next_state = ST_RUN;
                end
            end
            ST_RUN: begin
                w_next_state = ST_RUN;
            end
            default: begin
                w_next_state = ST_INIT;
            end
        endcase
    end

    assign o_busy      = (r_state == ST_INIT);
    assign o_init_addr = r_cnt;
    assign o_init_data = DATA_W'(init_word(32'(r_cnt)));

endmodule

// File: rtl/dm_param.sv
// Single-port byte-writable memory with a post-reset initialisation sweep and a
// fully pipelined read path of 1 or 2 cycles latency.
module dm_param
    import dm_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 4,
    parameter int READ_LAT = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_be,
    output logic                rsp_valid,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                init_busy
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int NB    = DATA_W / 8;

    logic              w_busy;
    logic              w_seq_we;
    logic [ADDR_W-1:0] w_seq_addr;
    logic [DATA_W-1:0] w_seq_data;

    dm_init_seq #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_init_seq (
        .clk         (clk),
        .rst         (rst),
        .o_busy      (w_busy),
        .o_init_we   (w_seq_we),
        .o_init_addr (w_seq_addr),
        .o_init_data (w_seq_data)
    );

    assign init_busy = w_busy;
    assign req_ready = ~w_busy;

    logic w_acc;
    logic w_rd_acc;
    logic w_wr_acc;
    logic w_init_we;

    // Writes are suppressed while reset is held so the array only ever changes
    // through the sweep or an accepted request.
    assign w_acc     = req_valid & req_ready;
    assign w_rd_acc  = w_acc & ~req_we;
    assign w_wr_acc  = w_acc & req_we & rst;
    assign w_init_we = w_seq_we & rst;

    logic [NB-1:0]     w_mem_be;
    logic [ADDR_W-1:0] w_mem_addr;
    logic [DATA_W-1:0] w_mem_wdata;

    always_comb begin
        w_mem_be    = '0;
        w_mem_addr  = req_addr;
        w_mem_wdata = req_wdata;
        if (w_init_we) begin
            w_mem_be    = '1;
            w_mem_addr  = w_seq_addr;
            w_mem_wdata = w_seq_data;
        end else if (w_wr_acc) begin
            w_mem_be = req_be;
        end
    end

    logic [DATA_W-1:0] r_mem [DEPTH];

    // NOTE: the array has no reset branch; its contents come from the sweep,
    // which keeps it mappable onto RAM macros.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NB; i++) begin
            if (w_mem_be[i]) begin
                r_mem[w_mem_addr][8*i +: 8] <= w_mem_wdata[8*i +: 8];
            end
        end
    end

    logic [DATA_W-1:0] w_rd_word;
    logic              r_rsp_valid;
    logic [DATA_W-1:0] r_rsp_rdata;

    // The array is read before this edge's write lands, so a read in the cycle
    // after a write already sees the new contents.
    assign w_rd_word = r_mem[req_addr];

    generate
        if (READ_LAT == 1) begin : g_lat1
            always_ff @(posedge clk) begin
                if (!rst) begin
                    r_rsp_valid <= 1'b0;
                    r_rsp_rdata <= '0;
                end else begin
                    r_rsp_valid <= w_rd_acc;
                    if (w_rd_acc) begin
                        r_rsp_rdata <= w_rd_word;
                    end
                end
            end
        end else begin : g_lat2
            logic              r_s1_valid;
            logic [DATA_W-1:0] r_s1_data;

            always_ff @(posedge clk) begin
                if (!rst) begin
                    r_s1_valid  <= 1'b0;
                    r_rsp_valid <= 1'b0;
                    r_rsp_rdata <= '0;
                end else begin
                    r_s1_valid  <= w_rd_acc;
                    r_rsp_valid <= r_s1_valid;
                    if (r_s1_valid) begin
                        r_rsp_rdata <= r_s1_data;
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (w_rd_acc) begin
                    r_s1_data <= w_rd_word;
                end
            end
        end
    endgenerate

    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;

endmodule

// File: tb/tb_dm_param.sv
// Directed bench for dm_param: two 16-bit instances (latency 1 and 2) share
// one stimulus stream; a 32-bit/64-word instance covers the wide configuration.
module tb_dm_param;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_we;
    logic [3:0]  req_addr;
    logic [15:0] req_wdata;
    logic [1:0]  req_be;

    logic        a_ready, a_valid, a_busy;
    logic [15:0] a_rdata;
    logic        b_ready, b_valid, b_busy;
    logic [15:0] b_rdata;

    logic        c_rst;
    logic        c_req_valid;
    logic        c_req_we;
    logic [5:0]  c_req_addr;
    logic [31:0] c_req_wdata;
    logic [3:0]  c_req_be;
    logic        c_ready, c_valid, c_busy;
    logic [31:0] c_rdata;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dm_param #(.DATA_W(16), .ADDR_W(4), .READ_LAT(1)) dut_a (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(a_ready),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(a_valid), .rsp_rdata(a_rdata), .init_busy(a_busy)
    );

    dm_param #(.DATA_W(16), .ADDR_W(4), .READ_LAT(2)) dut_b (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(b_ready),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(b_valid), .rsp_rdata(b_rdata), .init_busy(b_busy)
    );

    dm_param #(.DATA_W(32), .ADDR_W(6), .READ_LAT(1)) dut_c (
        .clk(clk), .rst(c_rst), .req_valid(c_req_valid), .req_ready(c_ready),
        .req_we(c_req_we), .req_addr(c_req_addr), .req_wdata(c_req_wdata), .req_be(c_req_be),
        .rsp_valid(c_valid), .rsp_rdata(c_rdata), .init_busy(c_busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] addr, input logic [15:0] data, input logic [1:0] be);
        req_valid = 1'b1; req_we = 1'b1;
        req_addr = addr; req_wdata = data; req_be = be;
        step();
        req_valid = 1'b0; req_we = 1'b0;
    endtask

    // Single read: A answers one cycle after acceptance, B one cycle later.
    task automatic rd_check(input string tag, input logic [3:0] addr, input logic [15:0] exp);
        req_valid = 1'b1; req_we = 1'b0; req_addr = addr;
        step();
        req_valid = 1'b0;
        check({tag, " a_valid"}, 32'(a_valid), 32'd1);
        check({tag, " a_data"}, 32'(a_rdata), 32'(exp));
        check({tag, " b_early"}, 32'(b_valid), 32'd0);
        step();
        check({tag, " b_valid"}, 32'(b_valid), 32'd1);
        check({tag, " b_data"}, 32'(b_rdata), 32'(exp));
        check({tag, " a_pulse"}, 32'(a_valid), 32'd0);
    endtask

    // Counts cycles with init_busy high (A instance), starting at the current sample.
    task automatic sweep_len(output int n);
        n = 0;
        while (a_busy && n < 200) begin
            n++;
            step();
        end
    endtask

    task automatic c_rd_check(input string tag, input logic [5:0] addr, input logic [31:0] exp);
        c_req_valid = 1'b1; c_req_we = 1'b0; c_req_addr = addr;
        step();
        c_req_valid = 1'b0;
        check({tag, " valid"}, 32'(c_valid), 32'd1);
        check({tag, " data"}, c_rdata, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] img [16];
        int          n;
        logic        seen;

        img = '{16'h3ADC, 16'h0000, 16'h1342, 16'hADDE, 16'hEFBE, 16'hFFFF, 16'hAAAA,
                16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000,
                16'h0000, 16'h0000};

        rst = 1'b0; c_rst = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
        c_req_valid = 1'b0; c_req_we = 1'b0; c_req_addr = '0; c_req_wdata = '0; c_req_be = '0;

        // One-cycle reset, then the 16-cycle sweep.
        step();
        check("rst busy", 32'(a_busy), 32'd1);
        check("rst ready", 32'(a_ready), 32'd0);
        check("rst a_valid", 32'(a_valid), 32'd0);
        check("rst a_rdata", 32'(a_rdata), 32'd0);
        check("rst b_rdata", 32'(b_rdata), 32'd0);
        rst = 1'b1;
        sweep_len(n);
        check("sweep len", 32'(n), 32'd16);
        check("ready after sweep", 32'(a_ready), 32'd1);
        check("b ready after sweep", 32'(b_ready), 32'd1);

        for (int i = 0; i < 16; i++) begin
            rd_check($sformatf("init word %0d", i), 4'(i), img[i]);
        end

        // Byte-enable writes.
        wr(4'd5, 16'h1234, 2'b01);
        rd_check("be low", 4'd5, 16'hFF34);
        wr(4'd5, 16'hAB00, 2'b10);
        rd_check("be high", 4'd5, 16'hAB34);
        wr(4'd5, 16'h0000, 2'b00);
        rd_check("be none", 4'd5, 16'hAB34);

        // Read immediately after write to the same address.
        wr(4'd3, 16'h5A5A, 2'b11);
        rd_check("b2b", 4'd3, 16'h5A5A);

        // Streaming reads on consecutive cycles.
        req_valid = 1'b1; req_we = 1'b0; req_addr = 4'd0;
        step();
        check("stream a0", 32'(a_rdata), 32'h3ADC);
        req_addr = 4'd1;
        step();
        check("stream a1 valid", 32'(a_valid), 32'd1);
        check("stream a1", 32'(a_rdata), 32'h0000);
        check("stream b0", 32'(b_rdata), 32'h3ADC);
        req_addr = 4'd2;
        step();
        check("stream a2 valid", 32'(a_valid), 32'd1);
        check("stream a2", 32'(a_rdata), 32'h1342);
        check("stream b1 valid", 32'(b_valid), 32'd1);
        check("stream b1", 32'(b_rdata), 32'h0000);
        req_valid = 1'b0;
        step();
        check("stream a idle", 32'(a_valid), 32'd0);
        check("stream a hold", 32'(a_rdata), 32'h1342);
        check("stream b2 valid", 32'(b_valid), 32'd1);
        check("stream b2", 32'(b_rdata), 32'h1342);
        step();
        check("stream b idle", 32'(b_valid), 32'd0);
        check("stream b hold", 32'(b_rdata), 32'h1342);

        // Reset right after an accepted read.
        wr(4'd9, 16'h7777, 2'b11);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 4'd9;
        step();
        req_valid = 1'b0;
        rst = 1'b0;
        step();
        check("rstrun a_valid", 32'(a_valid), 32'd0);
        check("rstrun a_rdata", 32'(a_rdata), 32'd0);
        check("rstrun b_valid", 32'(b_valid), 32'd0);
        check("rstrun b_rdata", 32'(b_rdata), 32'd0);
        check("rstrun busy", 32'(a_busy), 32'd1);
        rst = 1'b1;
        seen = 1'b0;
        n = 0;
        while (a_busy && n < 200) begin
            seen = seen | a_valid | b_valid;
            n++;
            step();
        end
        check("rstrun sweep len", 32'(n), 32'd16);
        check("rstrun no rsp", 32'(seen), 32'd0);
        rd_check("rstrun addr9", 4'd9, 16'h0000);

        // Reset mid-sweep restarts from word 0; requests during the sweep are ignored.
        wr(4'd1, 16'h4321, 2'b11);
        rst = 1'b0;
        step();
        rst = 1'b1;
        for (int i = 0; i < 5; i++) step();
        rst = 1'b0;
        step();
        rst = 1'b1;
        req_valid = 1'b1; req_we = 1'b1; req_addr = 4'd1; req_wdata = 16'hFFFF; req_be = 2'b11;
        seen = 1'b0;
        n = 0;
        while (a_busy && n < 200) begin
            seen = seen | a_valid | b_valid;
            n++;
            step();
        end
        req_valid = 1'b0; req_we = 1'b0;
        check("midinit sweep len", 32'(n), 32'd16);
        check("midinit no rsp", 32'(seen), 32'd0);
        rd_check("midinit addr1", 4'd1, 16'h0000);
        rd_check("midinit addr6", 4'd6, 16'hAAAA);

        // Wide configuration.
        c_rst = 1'b1;
        n = 0;
        while (c_busy && n < 200) begin
            n++;
            step();
        end
        check("c sweep len", 32'(n), 32'd64);
        check("c ready", 32'(c_ready), 32'd1);
        c_rd_check("c word0", 6'd0, 32'h00003ADC);
        c_rd_check("c word6", 6'd6, 32'h0000AAAA);
        c_rd_check("c word63 init", 6'd63, 32'h00000000);
        c_req_valid = 1'b1; c_req_we = 1'b1; c_req_addr = 6'd63;
        c_req_wdata = 32'hFF000000; c_req_be = 4'b1000;
        step();
        c_req_valid = 1'b0; c_req_we = 1'b0;
        c_rd_check("c word63", 6'd63, 32'hFF000000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
